alarm_user_ctrl: RTL and testbench

Button front-end that initiates the time-set and alarm-control traffic consumed by the alarm-clock top level. It debounces four raw push-buttons and runs a menu FSM to pick the target (wall clock or alarm k) and edit hour/minute. It converts the edited value into a POSIX write with a one-cycle enable, and outputs alarm off/snooze strobes when idle. It sits in the 50 MHz domain beside `posix_time_watches`.

---
 rtl/alarm_user_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_alarm_user_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_user_ctrl.sv
// Button front-end for the alarm clock: debounce, menu FSM, time/alarm writes, off/snooze strobes.
// Optional hold-to-repeat on up/down while editing: define ALARM_AUTOREPEAT_EN.
module alarm_user_ctrl #(
   parameter int unsigned ALARMS_CNT      = 7,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000,
   parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  btn_mode_i,
   input  logic                  btn_ok_i,
   input  logic                  btn_up_i,
   input  logic                  btn_down_i,
   input  logic [31:0]           cur_posix_time_i,
   input  logic [4:0]            cur_hour_i,
   input  logic [5:0]            cur_min_i,
   input  logic [5:0]            cur_sec_i,
   output logic [31:0]           usr_posix_time_o,
   output logic                  usr_posix_time_en_o,
   output logic [ALARMS_CNT-1:0] alarm_set_en_o,
   output logic                  alarm_off_stb_o,
   output logic                  alarm_snooze_stb_o,
   output logic [1:0]            edit_state_o,
   output logic [2:0]            edit_target_o,
   output logic [4:0]            edit_hour_o,
   output logic [5:0]            edit_min_o
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_SEL, S_HOUR, S_MIN, S_COMMIT} state_t;

   state_t                r_state, w_state_nx;
   logic [3:0]            w_raw, r_sync1, r_sync2, r_stable, r_press;
   logic [DBW-1:0]        r_db_cnt [4];
   logic [TOW-1:0]        r_to_cnt;
   logic [2:0]            r_target, w_target_nx;
   logic [4:0]            r_hour, w_hour_nx;
   logic [5:0]            r_min, w_min_nx;
   logic [31:0]           r_usr_time, w_usr_time_nx, w_commit_val;
   logic                  r_wr_en, w_wr_en_nx, r_off, w_off_nx, r_snz, w_snz_nx;
   logic [ALARMS_CNT-1:0] r_alarm_en, w_alarm_en_nx;
   logic [1:0]            w_rep;
   logic                  w_editing, w_up_any, w_dn_any, w_any_ev, w_timeout;
   logic                  w_ev_mode, w_ev_ok, w_ev_up, w_ev_dn;
   logic signed [32:0]    w_edit_min, w_cur_min, w_d, w_d_adj;

   assign w_raw = {btn_down_i, btn_up_i, btn_ok_i, btn_mode_i};

   // A level is accepted only after DEBOUNCE_CYCLES consecutive samples differ from it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_press  <= '0;
         for (int unsigned i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_press <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               r_db_cnt[i] <= '0;
               r_stable[i] <= r_sync2[i];
               r_press[i]  <= r_sync2[i];
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   assign w_editing = (r_state == S_HOUR) || (r_state == S_MIN);

`ifdef ALARM_AUTOREPEAT_EN
   localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
   logic [LW-1:0] r_hold_cnt [2];

   always_comb begin
      for (int unsigned i = 0; i < 2; i++)
         w_rep[i] = r_stable[2+i] && w_editing && (r_hold_cnt[i] == LW'(LONG_CYCLES));
   end

   // Reload so the next repeat lands exactly REPEAT_CYCLES later.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned i = 0; i < 2; i++) r_hold_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            if (!r_stable[2+i] || !w_editing) r_hold_cnt[i] <= '0;
            else if (w_rep[i])                r_hold_cnt[i] <= LW'(LONG_CYCLES - REPEAT_CYCLES + 1);
            else                              r_hold_cnt[i] <= r_hold_cnt[i] + LW'(1);
         end
      end
   end
`else
   assign w_rep = '0;
`endif

   assign w_up_any  = r_press[2] | w_rep[0];
   assign w_dn_any  = r_press[3] | w_rep[1];
   assign w_ev_mode = r_press[0];
   assign w_ev_ok   = r_press[1] & ~r_press[0];
   assign w_ev_up   = w_up_any & ~r_press[0] & ~r_press[1];
   assign w_ev_dn   = w_dn_any & ~r_press[0] & ~r_press[1] & ~w_up_any;
   assign w_any_ev  = r_press[0] | r_press[1] | w_up_any | w_dn_any;
   assign w_timeout = (r_to_cnt == TOW'(TIMEOUT_CYCLES));

   assign w_edit_min = $signed({28'd0, r_hour}) * 33'sd60 + $signed({27'd0, r_min});
   assign w_cur_min  = $signed({28'd0, cur_hour_i}) * 33'sd60 + $signed({27'd0, cur_min_i});
   assign w_d        = (w_edit_min - w_cur_min) * 33'sd60 - $signed({27'd0, cur_sec_i});
   assign w_d_adj    = ((r_target != 3'd0) && (w_d <= 33'sd0)) ? w_d + 33'sd86400 : w_d;
   assign w_commit_val = 32'($unsigned(w_d_adj) + {1'b0, cur_posix_time_i});

   always_comb begin
      w_state_nx    = r_state;
      w_target_nx   = r_target;
      w_hour_nx     = r_hour;
      w_min_nx      = r_min;
      w_usr_time_nx = r_usr_time;
      w_wr_en_nx    = 1'b0;
      w_alarm_en_nx = '0;
      w_off_nx      = 1'b0;
      w_snz_nx      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ev_mode) begin
               w_state_nx  = S_SEL;
               w_target_nx = '0;
            end else if (w_ev_ok) w_off_nx = 1'b1;
            else if (w_ev_up || w_ev_dn) w_snz_nx = 1'b1;
         end
         S_SEL: begin
            if (w_ev_mode) w_state_nx = S_IDLE;
            else if (w_ev_ok) begin
               w_state_nx = S_HOUR;
               w_hour_nx  = cur_hour_i;
               w_min_nx   = cur_min_i;
            end
            else if (w_ev_up) w_target_nx = (r_target == 3'(ALARMS_CNT)) ? 3'd0 : r_target + 3'd1;
            else if (w_ev_dn) w_target_nx = (r_target == 3'd0) ? 3'(ALARMS_CNT) : r_target - 3'd1;
            else if (w_timeout) w_state_nx = S_IDLE;
         end
         S_HOUR: begin
            if (w_ev_mode) w_state_nx = S_IDLE;
            else if (w_ev_ok) w_state_nx = S_MIN;
            else if (w_ev_up) w_hour_nx = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            else if (w_ev_dn) w_hour_nx = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
            else if (w_timeout) w_state_nx = S_IDLE;
         end
         S_MIN: begin
            if (w_ev_mode) w_state_nx = S_HOUR;
            else if (w_ev_ok) w_state_nx = S_COMMIT;
            else if (w_ev_up) w_min_nx = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            else if (w_ev_dn) w_min_nx = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
            else if (w_timeout) w_state_nx = S_IDLE;
         end
         S_COMMIT: begin
            w_state_nx    = S_IDLE;
            w_usr_time_nx = w_commit_val;
            if (r_target == 3'd0) w_wr_en_nx = 1'b1;
            else w_alarm_en_nx = {{(ALARMS_CNT-1){1'b0}}, 1'b1} << (r_target - 3'd1);
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= S_IDLE;
         r_target   <= '0;
         r_hour     <= '0;
         r_min      <= '0;
         r_usr_time <= '0;
         r_wr_en    <= 1'b0;
         r_alarm_en <= '0;
         r_off      <= 1'b0;
         r_snz      <= 1'b0;
         r_to_cnt   <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_target   <= w_target_nx;
         r_hour     <= w_hour_nx;
         r_min      <= w_min_nx;
         r_usr_time <= w_usr_time_nx;
         r_wr_en    <= w_wr_en_nx;
         r_alarm_en <= w_alarm_en_nx;
         r_off      <= w_off_nx;
         r_snz      <= w_snz_nx;
         if ((r_state == S_IDLE) || w_any_ev || w_timeout) r_to_cnt <= '0;
         else r_to_cnt <= r_to_cnt + TOW'(1);
      end
   end

   always_comb begin
      case (r_state)
         S_SEL:            edit_state_o = 2'd1;
         S_HOUR:           edit_state_o = 2'd2;
         S_MIN, S_COMMIT:  edit_state_o = 2'd3;
         default:          edit_state_o = 2'd0;
      endcase
   end

   assign usr_posix_time_o    = r_usr_time;
   assign usr_posix_time_en_o = r_wr_en;
   assign alarm_set_en_o      = r_alarm_en;
   assign alarm_off_stb_o     = r_off;
   assign alarm_snooze_stb_o  = r_snz;
   assign edit_target_o       = r_target;
   assign edit_hour_o         = r_hour;
   assign edit_min_o          = r_min;

endmodule

// File: tb/tb_alarm_user_ctrl.sv
// Self-checking bench for alarm_user_ctrl: directed scenarios plus a random button walk
// checked against an event-level menu model.
module tb_alarm_user_ctrl;

   localparam int AC = 7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        b_mode, b_ok, b_up, b_dn;
   logic [31:0] c_p;
   logic [4:0]  c_h;
   logic [5:0]  c_m, c_s;
   logic [31:0] usr_time;
   logic        usr_en, off_stb, snz_stb;
   logic [AC-1:0] al_en;
   logic [1:0]  ed_state;
   logic [2:0]  ed_tgt;
   logic [4:0]  ed_hr;
   logic [5:0]  ed_mn;

   alarm_user_ctrl #(
      .ALARMS_CNT(AC), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(40),
      .REPEAT_CYCLES(10), .TIMEOUT_CYCLES(200)
   ) dut (
      .clk_i(clk), .rst_i(rst_n),
      .btn_mode_i(b_mode), .btn_ok_i(b_ok), .btn_up_i(b_up), .btn_down_i(b_dn),
      .cur_posix_time_i(c_p), .cur_hour_i(c_h), .cur_min_i(c_m), .cur_sec_i(c_s),
      .usr_posix_time_o(usr_time), .usr_posix_time_en_o(usr_en),
      .alarm_set_en_o(al_en), .alarm_off_stb_o(off_stb), .alarm_snooze_stb_o(snz_stb),
      .edit_state_o(ed_state), .edit_target_o(ed_tgt),
      .edit_hour_o(ed_hr), .edit_min_o(ed_mn)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Strobe monitor.
   int n_off = 0, n_snz = 0, n_wr = 0, n_al = 0, last_off_cyc = -1;
   logic [31:0]   last_val = '0;
   logic [AC-1:0] last_al  = '0;
   always @(negedge clk) begin
      if (off_stb) begin n_off++; last_off_cyc = cyc; end
      if (snz_stb) n_snz++;
      if (usr_en) begin n_wr++; last_val = usr_time; end
      if (|al_en) begin n_al++; last_al = al_en; last_val = usr_time; end
   end

   // Reference model: menu position and expected strobe history.
   int m_st = 0, m_tgt = 0, m_hr = 0, m_mn = 0;
   int e_off = 0, e_snz = 0, e_wr = 0, e_al = 0;
   logic [31:0]   e_val = '0;
   logic [AC-1:0] e_al_vec = '0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: b_mode = v;
         1: b_ok   = v;
         2: b_up   = v;
         default: b_dn = v;
      endcase
   endtask

   task automatic model_commit();
      longint d;
      logic [63:0] sum;
      d = ((longint'(m_hr) * 60 + m_mn) - (longint'(c_h) * 60 + c_m)) * 60 - c_s;
      if (m_tgt != 0 && d <= 0) d += 86400;
      sum = 64'(longint'(c_p) + d);
      e_val = sum[31:0];
      if (m_tgt == 0) e_wr++;
      else begin
         e_al++;
         e_al_vec = '0;
         e_al_vec[m_tgt-1] = 1'b1;
      end
   endtask

   task automatic model_event(input int b);
      case (m_st)
         0: if (b == 0) begin m_st = 1; m_tgt = 0; end
            else if (b == 1) e_off++;
            else e_snz++;
         1: if (b == 0) m_st = 0;
            else if (b == 1) begin m_st = 2; m_hr = c_h; m_mn = c_m; end
            else if (b == 2) m_tgt = (m_tgt + 1) % (AC + 1);
            else m_tgt = (m_tgt + AC) % (AC + 1);
         2: if (b == 0) m_st = 0;
            else if (b == 1) m_st = 3;
            else if (b == 2) m_hr = (m_hr + 1) % 24;
            else m_hr = (m_hr + 23) % 24;
         default:
            if (b == 0) m_st = 2;
            else if (b == 1) begin model_commit(); m_st = 0; end
            else if (b == 2) m_mn = (m_mn + 1) % 60;
            else m_mn = (m_mn + 59) % 60;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      tick(12);
      set_btn(b, 1'b0);
      tick(12);
      model_event(b);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},  64'(ed_state), 64'(m_st));
      check({tag, ".target"}, 64'(ed_tgt),   64'(m_tgt));
      check({tag, ".hour"},   64'(ed_hr),    64'(m_hr));
      check({tag, ".min"},    64'(ed_mn),    64'(m_mn));
      check({tag, ".n_off"},  64'(n_off),    64'(e_off));
      check({tag, ".n_snz"},  64'(n_snz),    64'(e_snz));
      check({tag, ".n_wr"},   64'(n_wr),     64'(e_wr));
      check({tag, ".n_al"},   64'(n_al),     64'(e_al));
      if (e_wr + e_al > 0) check({tag, ".value"}, 64'(last_val), 64'(e_val));
      if (e_al > 0)        check({tag, ".al_vec"}, 64'(last_al), 64'(e_al_vec));
   endtask

   task automatic set_time(input int h, input int m, input int s, input logic [31:0] p);
      c_h = 5'(h); c_m = 6'(m); c_s = 6'(s); c_p = p;
   endtask

   initial begin
      int c0, n_up, r, b;
      rst_n = 1'b0;
      b_mode = 1'b0; b_ok = 1'b0; b_up = 1'b0; b_dn = 1'b0;
      set_time(12, 0, 30, 32'd1000030);
      tick(3);
      check("rst.time", 64'(usr_time), 64'd0);
      check("rst.en",   64'({usr_en, al_en, off_stb, snz_stb}), 64'd0);
      check_all("rst");
      rst_n = 1'b1;
      tick(3);

      // Bouncy ok in IDLE: one off strobe, 7 cycles after the last rising edge.
      for (int i = 0; i < 10; i++) begin
         b_ok = ~b_ok;
         tick(2);
      end
      b_ok = 1'b1;
      c0 = cyc;
      tick(15);
      b_ok = 1'b0;
      tick(12);
      model_event(1);
      check("bounce.latency", 64'(last_off_cyc), 64'(c0 + 7));
      check_all("bounce");

      // Clock set to 14:00 from 12:00:30.
      press(0); press(1); press(2); press(2); press(1); press(1);
      check_all("clkset");
      check("clkset.literal", 64'(last_val), 64'd1007200);

      // Clock set with minute wrapping downward from 0.
      press(0); press(1); press(2); press(2); press(1); press(3);
      check("minwrap.min", 64'(ed_mn), 64'd59);
      press(1);
      check_all("minwrap");

      // Alarm 3 at 11:00 is already past today, so it lands tomorrow.
      press(0); press(2); press(2); press(2); press(1); press(3); press(1); press(1);
      check_all("alarm");
      check("alarm.literal", 64'(last_val), 64'd1082800);
      check("alarm.vec", 64'(last_al), 64'b0000100);

      // Timeout from HOUR.
      press(0); press(1);
      check_all("to.entered");
      tick(150);
      check_all("to.before");
      tick(60);
      m_st = 0;
      check_all("to.after");

      // mode and ok together from IDLE: mode wins, ok dropped.
      b_mode = 1'b1; b_ok = 1'b1;
      tick(12);
      b_mode = 1'b0; b_ok = 1'b0;
      tick(12);
      model_event(0);
      check_all("simul");
      press(0);
      check_all("simul.back");

      // Hold up for 80 cycles in HOUR starting at 22.
      set_time(22, 15, 0, 32'd5000000);
      press(0); press(1);
      b_up = 1'b1;
      tick(80);
      b_up = 1'b0;
      tick(12);
`ifdef ALARM_AUTOREPEAT_EN
      n_up = 1 + (80 - 40 - 1) / 10 + 1;
      check("repeat.literal", 64'(ed_hr), 64'd3);
`else
      n_up = 1;
      check("repeat.literal", 64'(ed_hr), 64'd23);
`endif
      for (int i = 0; i < n_up; i++) model_event(2);
      check_all("repeat");
      press(0);
      check_all("repeat.exit");

      // Random walk.
      for (int i = 0; i < 60; i++) begin
         set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), $urandom);
         r = $urandom_range(0, 99);
         b = (r < 15) ? 0 : (r < 50) ? 1 : (r < 75) ? 2 : 3;
         press(b);
         check_all($sformatf("rnd%0d", i));
      end
      if (m_st != 0) begin
         press(0);
         if (m_st != 0) press(0);
      end

      // Asynchronous reset while in MIN.
      set_time(7, 45, 10, 32'd123456789);
      press(0); press(1); press(1);
      check_all("rstmid.min");
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid.time", 64'(usr_time), 64'd0);
      check("rstmid.strb", 64'({usr_en, al_en, off_stb, snz_stb}), 64'd0);
      check("rstmid.view", 64'({ed_state, ed_tgt, ed_hr, ed_mn}), 64'd0);
      tick(3);
      rst_n = 1'b1;
      tick(20);
      m_st = 0; m_tgt = 0; m_hr = 0; m_mn = 0;
      check_all("rstmid.after");
      check("rstmid.time2", 64'(usr_time), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
